risc_wb_stage: RTL
==================

# risc_wb_stage

Parametrised writeback stage for the pipelined RISC CPU, sitting between the EX/memory stage and the register-file write port. It registers the writeback fields, selects the result onto Bus D by MD, and aligns and extends sub-word loads. A two-entry skid buffer absorbs register-file stalls, and the stage suppresses writes to R0 and keeps a retired-instruction count.

## Interface
- DATA_W, 32, datapath width (multiple of 16)
- ADDR_W, 5, register-address width
- R0_ZERO, 1, when 1 any write to register 0 is dropped (wb_rw forced 0)
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/WB fields valid
- ex_ready  out  1  stage can accept this cycle
- ex_rw  in  1  register write request
- ex_da  in  ADDR_W  destination register
- ex_md  in  2  result select: 0 ALU F, 1 memory, 2 N xor V, 3 hold
- ex_f  in  DATA_W  ALU/function-unit result
- ex_n_xor_v  in  1  set-less-than flag
- mem_data  in  DATA_W  data-memory read word
- ex_ld_size  in  2  0 byte, 1 half, 2/3 word
- ex_ld_signed  in  1  sign-extend sub-word load
- ex_addr_lo  in  2  byte address bits [1:0] of the load
- rf_stall  in  1  register file cannot take a write this cycle
- wb_valid  out  1  writeback entry presented
- wb_rw  out  1  qualified write enable (wb_valid, ex_rw, R0 rule)
- wb_da  out  ADDR_W  write address
- wb_bus_d  out  DATA_W  Bus D write data
- wb_retired  out  32  count of entries consumed

## Operation
- Accept: ex_valid && ex_ready. Bus D is computed at accept and stored, never recomputed.
- Consume: wb_valid && !rf_stall. Entries with wb_rw=0 are also consumed and counted.
- Bus D select:
  - md=0 → ex_f
  - md=1 → aligned load
  - md=2 → zero-extended ex_n_xor_v, i.e. {DATA_W-1 zeros, flag}
  - md=3 → last_d
- last_d is the most recently computed Bus D of any accepted entry. It updates on every accept, including md=3, where it keeps its value.
- Load align:
  - byte: lane ex_addr_lo
  - half: lane ex_addr_lo[1]; ex_addr_lo[0] is ignored
  - Extension is sign or zero per ex_ld_signed.
  - Word loads pass mem_data unchanged.
  - Lanes are little-endian.
- FSM over the buffer:
  - EMPTY: output empty. On accept → ONE.
  - ONE: output valid.
    - accept without consume → TWO (entry to skid)
    - consume without accept → EMPTY
    - both → ONE, output reloaded from the input
  - TWO: output and skid both full. On consume → ONE, skid moves to output.
- ex_ready = (state != TWO). It is a registered decode with no combinational path from rf_stall.
- Ordering is strictly FIFO.
- wb_retired increments on each consume and saturates at 32'hFFFFFFFF.

## Timing
- Latency: accept at edge N → wb_valid and data visible after edge N; earliest write at edge N+1.
- Throughput is one entry per cycle when rf_stall=0.
- Reset asserted, at any time including mid-operation:
  - State goes to EMPTY and both entries are discarded.
  - All outputs 0 except ex_ready=1 (registered 1 after the reset assertion). wb_valid, wb_rw, wb_da, wb_bus_d and wb_retired are all 0.
  - last_d = 0.
- Simultaneous accept and consume in ONE keeps the buffer at one entry with no bubble.
- In TWO, ex_valid is ignored and ex_* may change freely.
- Outputs are held stable while wb_valid && rf_stall.

## Configuration
- RISC_WB_FWD_EN defined: adds three outputs for the ID-stage bypass, driven every cycle:
  - fwd_valid (1), equal to wb_rw
  - fwd_da (ADDR_W), equal to wb_da
  - fwd_data (DATA_W), equal to wb_bus_d
- RISC_WB_FWD_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- risc_wb_pkg holds:
  - MD encodings: MD_ALU=0, MD_MEM=1, MD_SLT=2, MD_HOLD=3
  - load-size encodings: LD_BYTE, LD_HALF, LD_WORD
  - FSM state enum: EMPTY, ONE, TWO
  - the packed writeback-entry struct (rw, da, bus_d)
- One sub-module, risc_wb_load_align: combinational, taking mem_data, size, signed and addr_lo and returning the extended word.

## Test plan
- Reset release, then ex_valid with md=0, ex_f=32'h12345678, rw=1, da=3 → after one edge: wb_valid=1, wb_rw=1, wb_da=3, wb_bus_d=32'h12345678, wb_retired=1 after the next edge.
- Load byte with mem_data=32'h80FF7F01, addr_lo=3, signed=1 → 32'hFFFFFF80. With addr_lo=1, signed=0 → 32'h0000007F. Half load, addr_lo=2, signed=1 → 32'hFFFF80FF.
- md=2 with n_xor_v=1 → 32'h00000001. A following md=3 → 32'h00000001.
- rf_stall held for 3 cycles while issuing 4 back-to-back entries:
  - ex_ready drops after the second accept.
  - Outputs stay stable.
  - After release, all 4 retire in order with no loss or duplication.
- rw=1, da=0, R0_ZERO=1 → wb_valid=1, wb_rw=0, wb_retired still increments.
- Assert reset while in TWO → wb_valid=0, wb_bus_d=0, wb_retired=0, ex_ready=1. After release, an md=3 entry yields 32'h00000000.

Source files
------------

// File: rtl/risc_wb_pkg.sv
// Shared encodings, FSM states and the default-width writeback entry for the RISC writeback stage.
// Imported by the stage, its load aligner and its interface users.
package risc_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Bus D source select (MD field)
  localparam logic [1:0] MD_ALU  = 2'd0;
  localparam logic [1:0] MD_MEM  = 2'd1;
  localparam logic [1:0] MD_SLT  = 2'd2;
  localparam logic [1:0] MD_HOLD = 2'd3;

  // Load size; 2'd3 also decodes as a word
  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_e;

  // Default-width entry layout; the stage re-declares it at its own parameter widths.
  typedef struct packed {
    logic                 rw;
    logic [WB_ADDR_W-1:0] da;
    logic [WB_DATA_W-1:0] bus_d;
  } wb_entry_t;

endpackage

// File: rtl/risc_wb_if.sv
// EX->WB handshake plus register-file write port of the writeback stage.
// Optional ID-stage bypass outputs exist only when RISC_WB_FWD_EN is defined.
interface risc_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_rw;
  logic [ADDR_W-1:0] ex_da;
  logic [1:0]        ex_md;
  logic [DATA_W-1:0] ex_f;
  logic              ex_n_xor_v;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        ex_ld_size;
  logic              ex_ld_signed;
  logic [1:0]        ex_addr_lo;
  logic              rf_stall;
  logic              wb_valid;
  logic              wb_rw;
  logic [ADDR_W-1:0] wb_da;
  logic [DATA_W-1:0] wb_bus_d;
  logic [31:0]       wb_retired;
`ifdef RISC_WB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_da;
  logic [DATA_W-1:0] fwd_data;
`endif

  modport master (
    output ex_valid, ex_rw, ex_da, ex_md, ex_f, ex_n_xor_v, mem_data,
           ex_ld_size, ex_ld_signed, ex_addr_lo, rf_stall,
    input  ex_ready, wb_valid, wb_rw, wb_da, wb_bus_d, wb_retired
`ifdef RISC_WB_FWD_EN
    , input fwd_valid, fwd_da, fwd_data
`endif
  );

  modport slave (
    input  ex_valid, ex_rw, ex_da, ex_md, ex_f, ex_n_xor_v, mem_data,
           ex_ld_size, ex_ld_signed, ex_addr_lo, rf_stall,
    output ex_ready, wb_valid, wb_rw, wb_da, wb_bus_d, wb_retired
`ifdef RISC_WB_FWD_EN
    , output fwd_valid, fwd_da, fwd_data
`endif
  );

endinterface

// File: rtl/risc_wb_load_align.sv
// Load aligner: picks the little-endian byte/half lane and sign/zero extends; words pass through.
// Purely combinational, no state, no handshake.
module risc_wb_load_align
  import risc_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        size,
  input  logic              ld_signed,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_data[{addr_lo, 3'b000} +: 8];
    half_v = mem_data[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      LD_BYTE: data = {{(DATA_W-8){ld_signed & byte_v[7]}}, byte_v};
      LD_HALF: data = {{(DATA_W-16){ld_signed & half_v[15]}}, half_v};
      default: data = mem_data;
    endcase
  end

endmodule

// File: rtl/risc_wb_stage.sv
// Writeback stage: computes Bus D at accept, 2-entry skid FIFO, R0 write suppression, retire count.
// Latency 1 edge to wb_valid; ex_ready registered (low only when full), stable outputs under rf_stall; RISC_WB_FWD_EN adds bypass outputs.
module risc_wb_stage
  import risc_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int R0_ZERO = 1
) (
  input logic     clk,
  input logic     reset,
  risc_wb_if.slave bus
);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] bus_d;
  } entry_t;

  wb_state_e         state;
  entry_t            out_q;
  entry_t            skid_q;
  entry_t            in_e;
  logic [DATA_W-1:0] last_d;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] bus_d_new;
  logic [31:0]       retired_q;
  logic              ex_ready_q;
  logic              accept;
  logic              consume;
  logic              wb_valid;
  logic              wb_rw;
  logic              r0_hit;

  risc_wb_load_align #(.DATA_W(DATA_W)) u_align (
    .mem_data  (bus.mem_data),
    .size      (bus.ex_ld_size),
    .ld_signed (bus.ex_ld_signed),
    .addr_lo   (bus.ex_addr_lo),
    .data      (aligned)
  );

  always_comb begin
    bus_d_new = bus.ex_f;
    case (bus.ex_md)
      MD_MEM:  bus_d_new = aligned;
      MD_SLT:  bus_d_new = {{(DATA_W-1){1'b0}}, bus.ex_n_xor_v};
      MD_HOLD: bus_d_new = last_d;
      default: bus_d_new = bus.ex_f;
    endcase
  end

  assign in_e     = '{rw: bus.ex_rw, da: bus.ex_da, bus_d: bus_d_new};
  assign wb_valid = (state != EMPTY);
  assign accept   = bus.ex_valid && ex_ready_q;
  assign consume  = wb_valid && !bus.rf_stall;

  // ex_ready_q tracks (next state != TWO) so it never depends on rf_stall combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      last_d     <= '0;
      retired_q  <= '0;
      ex_ready_q <= 1'b1;
    end else begin
      if (accept) last_d <= bus_d_new;
      if (consume && (retired_q != 32'hFFFF_FFFF)) retired_q <= retired_q + 32'd1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_q <= in_e;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            skid_q     <= in_e;
            state      <= TWO;
            ex_ready_q <= 1'b0;
          end else if (consume && !accept) begin
            state <= EMPTY;
          end else if (accept && consume) begin
            out_q <= in_e;
          end
        end
        TWO: begin
          if (consume) begin
            out_q      <= skid_q;
            state      <= ONE;
            ex_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          ex_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign r0_hit = (R0_ZERO != 0) && (out_q.da == '0);
  assign wb_rw  = wb_valid && out_q.rw && !r0_hit;

  assign bus.ex_ready   = ex_ready_q;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_rw      = wb_rw;
  assign bus.wb_da      = out_q.da;
  assign bus.wb_bus_d   = out_q.bus_d;
  assign bus.wb_retired = retired_q;

`ifdef RISC_WB_FWD_EN
  assign bus.fwd_valid = wb_rw;
  assign bus.fwd_da    = out_q.da;
  assign bus.fwd_data  = out_q.bus_d;
`endif

endmodule
